// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - operand-fetch/writeback stage with 16x16 register file around an external ALU
// Optional build macro: RF_ZERO_REG_EN (register 0 hardwired to zero).
module exec_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 4,
  parameter int OP_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [OP_W+3*ADR_W-1:0]   instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      ld_en,
  input  logic [ADR_W-1:0]          ld_adr,
  input  logic [DATA_W-1:0]         ld_data,
  output logic [DATA_W-1:0]         alu_R,
  output logic [DATA_W-1:0]         alu_S,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_Y,
  input  logic                      alu_N,
  input  logic                      alu_Z,
  input  logic                      alu_C,
  output logic [2:0]                flags,
  output logic                      done,
  input  logic [ADR_W-1:0]          dbg_adr,
  output logic [DATA_W-1:0]         dbg_data
);

  localparam int NREGS = 2 ** ADR_W;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [ADR_W-1:0]  w_q, r_q, s_q;
  logic [DATA_W-1:0] op_r, op_s, y_q;
  logic [2:0]        flags_q;
  logic [DATA_W-1:0] rf [NREGS];
  logic              nop;

  function automatic logic [DATA_W-1:0] rf_rd(input logic [ADR_W-1:0] adr);
    if (ZERO_EN && adr == '0) return '0;
    return rf[adr];
  endfunction

  function automatic logic wr_ok(input logic [ADR_W-1:0] adr);
    return !(ZERO_EN && adr == '0);
  endfunction

  // Top three opcodes are unused by the ALU and treated as no-operations.
  assign nop = (op_q >= OP_W'(13));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      w_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      op_r    <= '0;
      op_s    <= '0;
      y_q     <= '0;
      flags_q <= 3'b000;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_en) begin
            if (wr_ok(ld_adr)) rf[ld_adr] <= ld_data;
          end else if (instr_valid) begin
            {op_q, w_q, r_q, s_q} <= instr;
            state <= S_READ;
          end
        end
        S_READ: begin
          op_r  <= rf_rd(r_q);
          op_s  <= rf_rd(s_q);
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (!nop) begin
            y_q     <= alu_Y;
            flags_q <= {alu_N, alu_Z, alu_C};
          end
          state <= S_WB;
        end
        S_WB: begin
          if (!nop && wr_ok(w_q)) rf[w_q] <= y_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == S_IDLE) && !ld_en;
  assign done        = (state == S_WB);
  assign alu_op      = (state == S_EXEC) ? op_q : '0;
  assign alu_R       = op_r;
  assign alu_S       = op_s;
  assign flags       = flags_q;
  // Combinational read: a same-cycle write is seen only after the edge.
  assign dbg_data    = rf_rd(dbg_adr);

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer with a behavioural ALU
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ld_en;
  logic [3:0]  ld_adr;
  logic [15:0] ld_data;
  logic [15:0] alu_R, alu_S, alu_Y;
  logic [3:0]  alu_op;
  logic        alu_N, alu_Z, alu_C;
  logic [2:0]  flags;
  logic        done;
  logic [3:0]  dbg_adr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  exec_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data),
    .alu_R(alu_R), .alu_S(alu_S), .alu_op(alu_op), .alu_Y(alu_Y),
    .alu_N(alu_N), .alu_Z(alu_Z), .alu_C(alu_C), .flags(flags), .done(done),
    .dbg_adr(dbg_adr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU subset: 0 pass S, 2 inc R, 4 add, 5 sub (C = borrow), 10 xor.
  always_comb begin
    logic [16:0] wide;
    wide = 17'd0;
    case (alu_op)
      4'h0: wide = {1'b0, alu_S};
      4'h2: wide = {1'b0, alu_R} + 17'd1;
      4'h4: wide = {1'b0, alu_R} + {1'b0, alu_S};
      4'h5: wide = {alu_R < alu_S, alu_R - alu_S};
      4'hA: wide = {1'b0, alu_R ^ alu_S};
      default: wide = 17'd0;
    endcase
    alu_Y = wide[15:0];
    alu_N = wide[15];
    alu_Z = (wide[15:0] == 16'h0000);
    alu_C = wide[16];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_adr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_adr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Called just after the accepting edge; done must appear on the second edge after it.
  task automatic wait_done(input string tag);
    int lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (done) lat = i;
    end
    check({tag, "_latency"}, lat, 2);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run_instr(input logic [15:0] ins, input string tag);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    #1;
    check({tag, "_ready"}, instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    reset = 1'b0; instr = '0; instr_valid = 1'b0; ld_en = 1'b0;
    ld_adr = '0; ld_data = '0; dbg_adr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", flags, 3'b000);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", instr_ready, 1);
    for (int a = 0; a < 16; a++) chk_reg($sformatf("rst_r%0d", a), 4'(a), 16'h0000);

    load(4'd1, 16'h0005);
    load(4'd2, 16'h0003);
    run_instr(16'h4312, "add");
    chk_reg("add_r3", 4'd3, 16'h0008);
    check("add_flags", flags, 3'b000);

    run_instr(16'h5421, "sub");
    chk_reg("sub_r4", 4'd4, 16'hFFFE);
    check("sub_flags", flags, 3'b101);

    run_instr(16'hA511, "xor");
    chk_reg("xor_r5", 4'd5, 16'h0000);
    check("xor_flags", flags, 3'b010);

    // Load and instruction presented together: load wins, instruction follows.
    @(negedge clk);
    ld_en = 1'b1; ld_adr = 4'd6; ld_data = 16'h1234;
    instr = 16'hE612; instr_valid = 1'b1;
    #1;
    check("ldpri_ready_low", instr_ready, 0);
    tick();
    ld_en = 1'b0;
    #1;
    check("ldpri_ready_high", instr_ready, 1);
    chk_reg("ldpri_r6_loaded", 4'd6, 16'h1234);
    tick();
    instr_valid = 1'b0;
    wait_done("nop");
    chk_reg("nop_r6", 4'd6, 16'h1234);
    check("nop_flags", flags, 3'b010);

    run_instr(16'h0711, "pass");
    chk_reg("pass_r7", 4'd7, 16'h0005);
    check("pass_flags", flags, 3'b000);

    load(4'd0, 16'h1234);
`ifdef RF_ZERO_REG_EN
    chk_reg("zr_ld_r0", 4'd0, 16'h0000);
    run_instr(16'h4010, "zr_add");
    chk_reg("zr_add_r0", 4'd0, 16'h0000);
    check("zr_add_flags", flags, 3'b000);
`else
    chk_reg("zr_ld_r0", 4'd0, 16'h1234);
    run_instr(16'h4010, "zr_add");
    chk_reg("zr_add_r0", 4'd0, 16'h1239);
    check("zr_add_flags", flags, 3'b000);
`endif

    // Increment r1, then reset while in EXEC: no writeback, everything cleared.
    @(negedge clk);
    instr = 16'h2111; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("abort_done", done, 0);
    check("abort_flags", flags, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", instr_ready, 1);
    begin
      int pulses = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (done) pulses++;
      end
      check("abort_no_done", pulses, 0);
    end
    chk_reg("abort_r1", 4'd1, 16'h0000);
    for (int a = 0; a < 16; a++) chk_reg($sformatf("abort_r%0d", a), 4'(a), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
